firebird7_in_gate1_tessent_tdr_w19_2: RTL and testbench
=======================================================

# firebird7_in_gate1_tessent_tdr_w19_2

IJTAG test data register that drives the 19-bit data override path of firebird7_in_gate1. It provides a 20-bit scan segment (1 select bit and 19 data bits) on the IJTAG network. It captures the current functional `data_out` for observation, and on update it holds `ijtag_select` and `ijtag_data_out`. These outputs feed the `ijtag_select` and `ijtag_data_in` inputs of `firebird7_in_gate1_tessent_data_mux_w19_2`, which sits directly downstream.

## Interface
- `DATA_WIDTH`, default 19: width of the data field of the shift and update registers.
- `DATA_RESET`, default 19'h0: reset value of the data update register.
- `ijtag_tck`  input  1  clock; all state updates on the rising edge.
- `ijtag_reset`  input  1  reset, synchronous, active-high.
- `ijtag_sel`  input  1  segment selected; gates capture, shift and update.
- `ijtag_ce`  input  1  capture enable.
- `ijtag_se`  input  1  shift enable.
- `ijtag_ue`  input  1  update enable.
- `ijtag_si`  input  1  scan in.
- `ijtag_so`  output  1  scan out; equals shift-register bit 0.
- `capture_data_in`  input  DATA_WIDTH  observed functional value, connected to the mux `data_out`.
- `ijtag_select`  output  1  update-register select bit; goes to the mux select.
- `ijtag_data_out`  output  DATA_WIDTH  update-register data; goes to the mux `ijtag_data_in`.

## Operation
- **State**
  - `sr[DATA_WIDTH:0]` is the shift register. Bit DATA_WIDTH is the select field; bits [DATA_WIDTH-1:0] are the data field.
  - `upd_sel` and `upd_data` form the update register.
- **Decoded operations, gated by `ijtag_sel`**
  - SHIFT = `ijtag_sel & ijtag_se`
  - CAPTURE = `ijtag_sel & ijtag_ce & ~ijtag_se`
  - UPDATE = `ijtag_sel & ijtag_ue`
- **Priority on `sr`:** reset, then SHIFT, then CAPTURE, then hold. A cycle with both `se` and `ce` high shifts and does not capture.
- **SHIFT:** `sr <= {ijtag_si, sr[DATA_WIDTH:1]}`.
  - The first bit scanned in lands in data bit 0 after DATA_WIDTH+1 shifts.
  - The last bit scanned in is the select bit.
- **CAPTURE**
  - `sr[DATA_WIDTH-1:0] <= capture_data_in`.
  - `sr[DATA_WIDTH] <= upd_sel`, so readback shows the current override state.
- **UPDATE:** `{upd_sel, upd_data} <= sr`, using the value of `sr` before the same edge. UPDATE is independent of SHIFT and CAPTURE, so a simultaneous SHIFT and UPDATE loads the pre-shift `sr`.
- **`ijtag_sel` low:** `sr`, `upd_sel` and `upd_data` all hold regardless of `ce`, `se` and `ue`.
- **`ijtag_so`:** combinational `sr[0]`, independent of `ijtag_sel`.
- **Outputs:** `ijtag_select = upd_sel` and `ijtag_data_out = upd_data`, both driven directly from flops with no glitch path.
- **Reset**
  - `sr` <= 0, `upd_sel` <= 0 (functional path selected), `upd_data` <= DATA_RESET.
  - Reset overrides every operation in the same cycle, including mid-shift; a partially shifted pattern is discarded.

## Timing
- Each of capture, shift and update takes effect at the first rising edge where its enable is sampled high. Outputs change after that edge.
- `ijtag_so` reflects the new `sr[0]` in the cycle after each shift edge, ready for the next segment's capture.
- Load latency:
  - A full load is DATA_WIDTH+1 SHIFT cycles followed by 1 UPDATE cycle.
  - The mux switches to IJTAG data on the edge that performs UPDATE.
- Reset output values:
  - `ijtag_select` = 0, `ijtag_data_out` = DATA_RESET, `ijtag_so` = 0.
  - Valid from the first rising edge with `ijtag_reset` = 1.
- No combinational path from any input to `ijtag_select` or `ijtag_data_out`.

## Test plan
- **Reset:** assert `ijtag_reset` for 1 cycle after random activity -> `ijtag_select` = 0, `ijtag_data_out` = 19'h0, `ijtag_so` = 0.
- **Shift and update:**
  - Stimulus: shift 20 bits encoding select = 1 and data = 19'h5A5A5 (data LSB first), then pulse `ue`.
  - Required: `ijtag_select` = 1 and `ijtag_data_out` = 19'h5A5A5 after the update edge, and unchanged during the shifts.
- **Capture readback:**
  - Stimulus: with `upd_sel` = 1 and `capture_data_in` = 19'h7FFFF, pulse `ce`, then shift 20 times.
  - Required: `ijtag_so` sequence is nineteen 1s followed by 1 (the select bit).
- **Deselected:** `ijtag_sel` = 0 with `se`, `ce` and `ue` pulsed -> `sr` and outputs unchanged; `ijtag_so` holds its value.
- **Simultaneous operations:**
  - `se` and `ce` together: shift occurs, no capture.
  - SHIFT and UPDATE together: the update register loads the pre-shift `sr`.
- **Reset mid-shift:** after 10 of 20 shifts, assert reset for 1 cycle, then resume with a full 20-shift load of 19'h00001 / select 1 and update -> `ijtag_data_out` = 19'h00001 and `ijtag_select` = 1, with no residue from the aborted pattern.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_2_if.sv
// IJTAG segment bundle for the firebird7_in_gate1 data-override TDR.
//   master : IJTAG network side (drives sel/ce/se/ue/si and the observed
//            functional value, receives scan-out and the update-register outputs)
//   slave  : the TDR itself
interface firebird7_in_gate1_tessent_tdr_w19_2_if #(
  parameter int DATA_WIDTH = 19
);
  logic                  ijtag_sel;
  logic                  ijtag_ce;
  logic                  ijtag_se;
  logic                  ijtag_ue;
  logic                  ijtag_si;
  logic                  ijtag_so;
  logic [DATA_WIDTH-1:0] capture_data_in;
  logic                  ijtag_select;
  logic [DATA_WIDTH-1:0] ijtag_data_out;

  modport master (
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data_in,
    input  ijtag_so, ijtag_select, ijtag_data_out
  );

  modport slave (
    input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data_in,
    output ijtag_so, ijtag_select, ijtag_data_out
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_2.sv
// IJTAG test data register driving the 19-bit data override path of
// firebird7_in_gate1. Scan segment is {select, data[DATA_WIDTH-1:0]}.
// Ports:
//   ijtag_tck   : clock, all state changes on the rising edge
//   ijtag_reset : synchronous active-high reset
//   bus (slave) : sel/ce/se/ue/si, scan-out, captured functional value,
//                 update-register select and data outputs
module firebird7_in_gate1_tessent_tdr_w19_2 #(
  parameter int                    DATA_WIDTH = 19,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET = '0
) (
  input  logic                                          ijtag_tck,
  input  logic                                          ijtag_reset,
  firebird7_in_gate1_tessent_tdr_w19_2_if.slave         bus
);

  logic [DATA_WIDTH:0]   sr_q, sr_d;
  logic                  upd_sel_q, upd_sel_d;
  logic [DATA_WIDTH-1:0] upd_data_q, upd_data_d;

  logic do_shift, do_capture, do_update;

  assign do_shift   = bus.ijtag_sel & bus.ijtag_se;
  assign do_capture = bus.ijtag_sel & bus.ijtag_ce & ~bus.ijtag_se;
  assign do_update  = bus.ijtag_sel & bus.ijtag_ue;

  always_comb begin
    sr_d       = sr_q;
    upd_sel_d  = upd_sel_q;
    upd_data_d = upd_data_q;
    if (do_shift) begin
      sr_d = {bus.ijtag_si, sr_q[DATA_WIDTH:1]};
    end else if (do_capture) begin
      // select field reads back the live override state
      sr_d = {upd_sel_q, bus.capture_data_in};
    end
    // update samples the pre-edge shift register, even while shifting
    if (do_update) begin
      {upd_sel_d, upd_data_d} = sr_q;
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr_q       <= '0;
      upd_sel_q  <= 1'b0;
      upd_data_q <= DATA_RESET;
    end else begin
      sr_q       <= sr_d;
      upd_sel_q  <= upd_sel_d;
      upd_data_q <= upd_data_d;
    end
  end

  assign bus.ijtag_so       = sr_q[0];
  assign bus.ijtag_select   = upd_sel_q;
  assign bus.ijtag_data_out = upd_data_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_2.sv
module tb_firebird7_in_gate1_tessent_tdr_w19_2;
  localparam int DW = 19;

  logic ijtag_tck;
  logic ijtag_reset;
  int   checks = 0;
  int   errors = 0;

  firebird7_in_gate1_tessent_tdr_w19_2_if #(.DATA_WIDTH(DW)) bus ();

  firebird7_in_gate1_tessent_tdr_w19_2 #(.DATA_WIDTH(DW), .DATA_RESET(19'h0)) dut (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .bus        (bus)
  );

  initial ijtag_tck = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  // Reference model: the segment as a bit queue, element 0 is the bit nearest
  // scan-out, element DW is the select field.
  bit            mq[$];
  bit            m_sel;
  logic [DW-1:0] m_data;
  logic [DW-1:0] cap_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, sel, ce, se, ue, si, input logic [DW-1:0] cap);
    bit            old_q[$];
    bit            old_sel;
    old_q   = mq;
    old_sel = m_sel;
    if (rst) begin
      mq = {};
      for (int i = 0; i <= DW; i++) mq.push_back(1'b0);
      m_sel  = 1'b0;
      m_data = '0;
      return;
    end
    if (!sel) return;
    if (se) begin
      void'(mq.pop_front());
      mq.push_back(si);
    end else if (ce) begin
      for (int i = 0; i < DW; i++) mq[i] = cap[i];
      mq[DW] = old_sel;
    end
    if (ue) begin
      for (int i = 0; i < DW; i++) m_data[i] = old_q[i];
      m_sel = old_q[DW];
    end
  endtask

  task automatic step(input logic rst, sel, ce, se, ue, si, input logic [DW-1:0] cap);
    @(negedge ijtag_tck);
    ijtag_reset         = rst;
    bus.ijtag_sel       = sel;
    bus.ijtag_ce        = ce;
    bus.ijtag_se        = se;
    bus.ijtag_ue        = ue;
    bus.ijtag_si        = si;
    bus.capture_data_in = cap;
    @(posedge ijtag_tck);
    model_edge(rst, sel, ce, se, ue, si, cap);
    #1;
    chk("model_select", {31'd0, bus.ijtag_select}, {31'd0, m_sel});
    chk("model_data",   {13'd0, bus.ijtag_data_out}, {13'd0, m_data});
    chk("model_so",     {31'd0, bus.ijtag_so}, {31'd0, mq[0]});
  endtask

  task automatic shift_bit(input logic si);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, si, cap_v);
  endtask

  task automatic load_pattern(input logic sel_bit, input logic [DW-1:0] data);
    for (int i = 0; i < DW; i++) shift_bit(data[i]);
    shift_bit(sel_bit);
  endtask

  task automatic pulse_update();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, cap_v);
  endtask

  task automatic random_step(input bit allow_rst);
    logic r;
    r = allow_rst && ($urandom_range(0, 49) == 0);
    step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom),
         $urandom_range(0, 5) == 0, 1'($urandom), DW'($urandom));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pat;
    cap_v = '0;
    for (int i = 0; i <= DW; i++) mq.push_back(1'b0);
    m_sel  = 1'b0;
    m_data = '0;

    // reset after random activity
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 40; i++) random_step(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("rst_select", {31'd0, bus.ijtag_select}, 32'd0);
    chk("rst_data",   {13'd0, bus.ijtag_data_out}, 32'd0);
    chk("rst_so",     {31'd0, bus.ijtag_so}, 32'd0);

    // shift and update 19'h5A5A5 / select 1
    pat = 19'h5A5A5;
    for (int i = 0; i <= DW; i++) begin
      shift_bit(i < DW ? pat[i] : 1'b1);
      chk("shift_hold_select", {31'd0, bus.ijtag_select}, 32'd0);
      chk("shift_hold_data",   {13'd0, bus.ijtag_data_out}, 32'd0);
    end
    pulse_update();
    chk("upd_select", {31'd0, bus.ijtag_select}, 32'd1);
    chk("upd_data",   {13'd0, bus.ijtag_data_out}, 32'h5A5A5);

    // capture readback with override active
    cap_v = 19'h7FFFF;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cap_v);
    for (int i = 0; i <= DW; i++) begin
      chk("capture_so_seq", {31'd0, bus.ijtag_so}, 32'd1);
      shift_bit(1'b0);
    end

    // deselected: nothing moves
    load_pattern(1'b0, 19'h0F0F1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 19'h12345);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'h12345);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 19'h12345);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 19'h12345);
    chk("desel_so",     {31'd0, bus.ijtag_so}, 32'd1);
    chk("desel_select", {31'd0, bus.ijtag_select}, 32'd1);
    chk("desel_data",   {13'd0, bus.ijtag_data_out}, 32'h5A5A5);

    // se and ce together: shift wins
    cap_v = 19'h7FFFF;
    load_pattern(1'b0, 19'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, cap_v);
    chk("se_ce_so", {31'd0, bus.ijtag_so}, 32'd0);

    // shift and update together: update sees pre-shift contents
    load_pattern(1'b0, 19'h12345);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, cap_v);
    chk("se_ue_select", {31'd0, bus.ijtag_select}, 32'd0);
    chk("se_ue_data",   {13'd0, bus.ijtag_data_out}, 32'h12345);

    // reset mid-shift, then a clean load
    for (int i = 0; i < 10; i++) shift_bit(1'($urandom));
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, cap_v);
    chk("midrst_so",   {31'd0, bus.ijtag_so}, 32'd0);
    chk("midrst_data", {13'd0, bus.ijtag_data_out}, 32'd0);
    load_pattern(1'b1, 19'h00001);
    pulse_update();
    chk("reload_select", {31'd0, bus.ijtag_select}, 32'd1);
    chk("reload_data",   {13'd0, bus.ijtag_data_out}, 32'h00001);

    // random traffic against the model
    for (int i = 0; i < 400; i++) random_step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
